truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that characterises one 3-input, 1-output truth-table logic block (one of the `0xNN` gate modules) by driving all eight input combinations in order. For each combination it waits a settle interval, samples the gate output several times with a majority vote, and assembles the 8-bit truth-table code. It then compares that code against an expected value. It sits between a test or configuration host and a single gate instance, and owns the gate's inputs during a sweep.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles the inputs are held before sampling; legal range 1–255.
- `SAMPLES`, 3: output samples per row; odd, legal range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  cancel the sweep in progress.
- `expected`  in  8  expected truth-table code, captured when start is accepted.
- `dut_in1`, `dut_in2`, `dut_in3`  out  1 each  drive the gate inputs.
- `dut_out`  in  1  gate output.
- `busy`  out  1  high from the cycle after start is accepted until DONE is left.
- `done`  out  1  one-cycle completion pulse.
- `code`  out  8  measured truth-table code.
- `match`  out  1  `code == expected`; valid when `done` is high, held until the next start.

## Operation
- Row index `r` runs 0..7. `{dut_in1,dut_in2,dut_in3} = r`, so `dut_in1` is the MSB. Outside a sweep the inputs are driven to 3'b000.
- Code bit mapping: `code[7-r]` = voted output for row `r`. Row 000 lands in the MSB, so a gate whose outputs for rows 000..111 are 0,0,1,1,1,1,0,1 yields 8'h3D.
- States:
  - IDLE: on `start` → SETTLE. Set r=0, `code`=0, `match`=0, latch `expected`.
  - SETTLE: hold for `SETTLE_CYCLES` cycles → SAMPLE.
  - SAMPLE: register `dut_out` each cycle for `SAMPLES` cycles, counting ones → STORE.
  - STORE: write `code[7-r] = (ones > SAMPLES/2)`, then clear the ones count. If r==7 → DONE; else r+1 → SETTLE.
  - DONE: `done`=1, `match` ← (`code`==latched expected) → IDLE.
- `abort` has priority over every transition. From any non-IDLE state the next state is IDLE: inputs return to 000, `code` is cleared to 0, no `done` pulse is produced, and `match` is left at 0.
- `start` is ignored while `busy`. If `start` and `abort` are both high in IDLE, the controller stays in IDLE.
- The ones counter is ceil(log2(SAMPLES+1)) bits wide. The settle counter is 8 bits. Neither counter ever wraps within its legal range.

## Timing
- Reset values: `dut_in*`=0, `busy`=0, `done`=0, `code`=8'h00, `match`=0, state IDLE, r=0.
- Reset asserted mid-sweep takes effect immediately (asynchronously) and restores all reset values. No `done` is produced.
- Per row: SETTLE_CYCLES + SAMPLES + 1 cycles.
- `done` rises exactly 8·(SETTLE_CYCLES+SAMPLES+1) edges after the edge that accepted `start`. With default parameters this is 64 edges. `done` is high for one cycle.
- `code` and `match` change only in STORE, DONE, start acceptance, abort, or reset.
- `dut_in*` change only on STORE→SETTLE transitions, on start acceptance (to row 0, which is already 000), and on return to IDLE.
- Back-to-back operation: a `start` held high during DONE is not accepted. It is accepted on the following IDLE cycle.

## Structure
- Package `truth_table_pkg` holds:
  - state enum (IDLE, SETTLE, SAMPLE, STORE, DONE);
  - `ROWS = 8`;
  - `CODE_W = 8`;
  - the row-to-code-bit mapping function (`7-r`).
- Sub-module `sample_voter`: ones counter plus majority compare, parameterised by `SAMPLES`, with clear/enable inputs. The FSM, settle counter and row counter live in `truth_table_sweeper`.

## Test plan
- Behavioural 0x3D gate, `expected`=8'h3D, `start` pulse → input rows 000..111 driven in order; `done` at edge 64; `code`=8'h3D; `match`=1.
- Same gate, `expected`=8'h3C → `code`=8'h3D, `match`=0.
- Gate output glitches for 1 of 3 samples on row 010 (reads 0 once) → majority gives 1; `code` is still 8'h3D.
- `abort` asserted during row 4 SETTLE → IDLE on the next edge; inputs 000; `code`=0; no `done`. A new `start` then completes normally.
- `rst_n` pulsed low during row 6 SAMPLE → all outputs at reset values immediately; no `done`. `start` pulses while `busy` have no effect on timing.
- SETTLE_CYCLES=1, SAMPLES=1 with a constant-1 gate → `code`=8'hFF; `done` at edge 24.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the 3-input truth-table sweeper.
// Row r of the sweep lands in code bit 7-r, so row 000 is the MSB.
package truth_table_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STORE,
        ST_DONE
    } state_e;

    localparam int ROWS   = 8;
    localparam int CODE_W = 8;

    function automatic logic [2:0] code_bit(input logic [2:0] r);
        return 3'(ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/sample_voter.sv
// Counts ones on din while enabled and reports a strict majority of SAMPLES.
module sample_voter #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic vote
);

    localparam int CNT_W = $clog2(SAMPLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && din)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign vote = (cnt_q > CNT_W'(SAMPLES / 2));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input rows of a 3-input gate, majority-votes its output per
// row and assembles the truth-table code, then compares it to an expected code.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] expected,
    output logic              dut_in1,
    output logic              dut_in2,
    output logic              dut_in3,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] code,
    output logic              match
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
    localparam logic [2:0] LAST_ROW    = 3'(ROWS - 1);

    state_e            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [2:0]        row_q, row_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] exp_q, exp_d;
    logic              match_q, match_d;
    logic              vote;
    logic              voter_clr;

    // The ones count restarts at every row boundary and on any cancelled sweep.
    assign voter_clr = (state_q == ST_IDLE) || (state_q == ST_STORE) || abort;

    sample_voter #(.SAMPLES(SAMPLES)) u_voter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (voter_clr),
        .en    (state_q == ST_SAMPLE),
        .din   (dut_out),
        .vote  (vote)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        row_d    = row_q;
        code_d   = code_q;
        exp_d    = exp_q;
        match_d  = match_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    row_d    = '0;
                    code_d   = '0;
                    match_d  = 1'b0;
                    exp_d    = expected;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            // The settle counter doubles as the sample-cycle counter.
            ST_SAMPLE: begin
                if (settle_q == SAMPLE_LAST) begin
                    state_d  = ST_STORE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_STORE: begin
                code_d[code_bit(row_q)] = vote;
                if (row_q == LAST_ROW) begin
                    state_d = ST_DONE;
                    // Resolved on entry so match is already valid alongside done.
                    match_d = (code_d == exp_q);
                end else begin
                    state_d = ST_SETTLE;
                    row_d   = row_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            row_d    = '0;
            code_d   = '0;
            match_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            row_q    <= '0;
            code_q   <= '0;
            exp_q    <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            row_q    <= row_d;
            code_q   <= code_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
        end
    end

    assign {dut_in1, dut_in2, dut_in3} = row_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign code  = code_q;
    assign match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised sweeps of a behavioural gate against a row/sample timing model,
// plus abort, reset and a minimal-parameter instance.
module tb_truth_table_sweeper;

    localparam int S = 4;
    localparam int N = 3;
    localparam int P = S + N + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, gate_out;
    logic [7:0] expected;
    logic       din1, din2, din3, busy, done, match;
    logic [7:0] code;

    logic       start1, abort1, gate1;
    logic [7:0] expected1;
    logic       d1_in1, d1_in2, d1_in3, busy1, done1, match1;
    logic [7:0] code1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(S), .SAMPLES(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_in1(din1), .dut_in2(din2), .dut_in3(din3), .dut_out(gate_out),
        .busy(busy), .done(done), .code(code), .match(match)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .SAMPLES(1)) u_dut_min (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected1),
        .dut_in1(d1_in1), .dut_in2(d1_in2), .dut_in3(d1_in3), .dut_out(gate1),
        .busy(busy1), .done(done1), .code(code1), .match(match1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".code"}, code, 0);
        chk({tag, ".match"}, match, 0);
        chk({tag, ".din"}, {din1, din2, din3}, 0);
    endtask

    // Entered and left at #1 after a rising edge with the controller in IDLE.
    task automatic sweep(input logic [7:0] tt, input logic [7:0] exp, input bit rnd_glitch,
                         input int glitch_row, input int abort_at, input int rst_at,
                         input bit busy_starts, input bit b2b);
        int ones, flips, row, ph;
        logic o;
        logic [7:0] mcode;
        start = 1'b1; expected = exp; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; expected = 8'($urandom);
        mcode = 8'h00; ones = 0; flips = 0;
        for (int k = 0; k <= 8 * P; k++) begin
            row = k / P; ph = k % P;
            if (k < 8 * P) begin
                chk("din", {din1, din2, din3}, row);
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                if (ph >= S && ph < S + N) begin
                    o = tt[7 - row];
                    if (row == glitch_row && ph == S) begin
                        o = ~o; flips++;
                    end else if (rnd_glitch && flips < (N - 1) / 2 && $urandom_range(1) == 1) begin
                        o = ~o; flips++;
                    end
                    ones += int'(o);
                    if (ph == S + N - 1) begin
                        mcode[7 - row] = (ones > N / 2);
                        ones = 0; flips = 0;
                    end
                end else begin
                    o = 1'($urandom_range(1));
                end
                gate_out = o;
                start = busy_starts ? 1'($urandom_range(1)) : 1'b0;
                if (k == abort_at) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0; start = 1'b0;
                    chk_idle("abort");
                    for (int j = 0; j < 8 * P; j++) begin
                        @(posedge clk); #1;
                        chk("abort.no_done", done, 0);
                    end
                    return;
                end
                if (k == rst_at) begin
                    start = 1'b0;
                    #1 rst_n = 1'b0;
                    #1 chk_idle("reset");
                    @(negedge clk) rst_n = 1'b1;
                    for (int j = 0; j < 8 * P; j++) begin
                        @(posedge clk); #1;
                        chk("reset.no_done", done, 0);
                    end
                    return;
                end
            end else begin
                chk("done", done, 1);
                chk("code", code, mcode);
                chk("match", match, (mcode == exp));
                chk("din_done", {din1, din2, din3}, 7);
                start = b2b;
            end
            @(posedge clk); #1;
        end
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("din_after", {din1, din2, din3}, 0);
        chk("code_held", code, mcode);
        chk("match_held", match, (mcode == exp));
    endtask

    initial begin
        int n;
        logic [7:0] tt, ex;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; gate_out = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; expected1 = 8'h00; gate1 = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk_idle("rst");
        chk("rst.min_busy", busy1, 0);
        chk("rst.min_code", code1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        sweep(8'h3D, 8'h3D, 0, -1, -1, -1, 0, 0);
        sweep(8'h3D, 8'h3C, 0, -1, -1, -1, 0, 0);
        sweep(8'h3D, 8'h3D, 0, 2, -1, -1, 0, 0);
        sweep(8'h3D, 8'h3D, 0, -1, 4 * P + 1, -1, 0, 0);
        sweep(8'h3D, 8'h3D, 0, -1, -1, -1, 0, 0);
        sweep(8'hA5, 8'hA5, 0, -1, -1, 6 * P + S + 1, 1, 0);
        sweep(8'hA5, 8'hA5, 1, -1, -1, -1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            tt = 8'($urandom);
            ex = ($urandom_range(1) == 1) ? tt : 8'($urandom);
            sweep(tt, ex, 1, -1, -1, -1, 1, (i % 2) == 0);
        end

        start1 = 1'b1; expected1 = 8'hFF;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("min.done_edge", n, 24);
        chk("min.code", code1, 8'hFF);
        chk("min.match", match1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
